// File: rtl/flush_ctrl.sv
// Per-thread pipeline flush controller: captures branch/exception flush requests, arbitrates
// round-robin between pending threads, issues invalidate+redirect pulses, and stalls drains.
module flush_ctrl #(
    parameter int unsigned NTHREADS = 4,
    parameter int unsigned DRAIN    = 5,
    parameter int unsigned PCW      = 32,
    localparam int unsigned TW      = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
    localparam int unsigned CW      = $clog2(DRAIN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                br_req_i,
    input  logic [TW-1:0]       br_thread_i,
    input  logic [PCW-1:0]      br_target_i,
    input  logic                exc_req_i,
    input  logic [TW-1:0]       exc_thread_i,
    input  logic [PCW-1:0]      exc_pc_i,
    output logic                invalidate_en_o,
    output logic [TW-1:0]       invalidate_thread_o,
    output logic                redirect_en_o,
    output logic [TW-1:0]       redirect_thread_o,
    output logic [PCW-1:0]      redirect_pc_o,
    output logic [NTHREADS-1:0] thread_stall_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {StIdle, StPend, StDrain} state_e;
    typedef enum logic {KindBr, KindExc} kind_e;

    state_e         state_q [NTHREADS];
    state_e         state_d [NTHREADS];
    kind_e          kind_q  [NTHREADS];
    kind_e          kind_d  [NTHREADS];
    logic [PCW-1:0] pc_q    [NTHREADS];
    logic [PCW-1:0] pc_d    [NTHREADS];
    logic [CW-1:0]  cnt_q   [NTHREADS];
    logic [CW-1:0]  cnt_d   [NTHREADS];

    logic [TW-1:0]  rr_q, rr_d;
    logic           inv_en_q, inv_en_d;
    logic [TW-1:0]  inv_thr_q, inv_thr_d;
    logic [PCW-1:0] rpc_q, rpc_d;

    logic           gnt_found;
    logic           collide;
    logic           issue;
    logic [TW-1:0]  gnt_idx;
    int unsigned    gnt_int;
    int unsigned    idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_int   = 0;
        idx       = 0;
        for (int unsigned k = 0; k < NTHREADS; k++) begin
            idx = (32'(rr_q) + k) % NTHREADS;
            if (!gnt_found && state_q[idx] == StPend) begin
                gnt_found = 1'b1;
                gnt_int   = idx;
            end
        end
        gnt_idx = TW'(gnt_int);
        // An older exception landing on the thread being granted a branch cancels the grant
        collide = gnt_found && kind_q[gnt_idx] == KindBr && exc_req_i && exc_thread_i == gnt_idx;
        issue   = gnt_found && !collide;

        for (int unsigned i = 0; i < NTHREADS; i++) begin
            state_d[i] = state_q[i];
            kind_d[i]  = kind_q[i];
            pc_d[i]    = pc_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (exc_req_i && exc_thread_i == TW'(i)) begin
                        state_d[i] = StPend;
                        kind_d[i]  = KindExc;
                        pc_d[i]    = exc_pc_i;
                    end else if (br_req_i && br_thread_i == TW'(i)) begin
                        state_d[i] = StPend;
                        kind_d[i]  = KindBr;
                        pc_d[i]    = br_target_i;
                    end
                end
                StPend: begin
                    if (kind_q[i] == KindBr && exc_req_i && exc_thread_i == TW'(i)) begin
                        kind_d[i] = KindExc;
                        pc_d[i]   = exc_pc_i;
                    end
                    if (issue && gnt_idx == TW'(i)) begin
                        state_d[i] = StDrain;
                        cnt_d[i]   = CW'(DRAIN - 1);
                    end
                end
                StDrain: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = StIdle;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end

        inv_en_d  = issue;
        inv_thr_d = issue ? gnt_idx : '0;
        rpc_d     = issue ? pc_q[gnt_idx] : '0;
        rr_d      = issue ? TW'((gnt_int + 1) % NTHREADS) : rr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NTHREADS; i++) begin
                state_q[i] <= StIdle;
                kind_q[i]  <= KindBr;
                pc_q[i]    <= '0;
                cnt_q[i]   <= '0;
            end
            rr_q      <= '0;
            inv_en_q  <= 1'b0;
            inv_thr_q <= '0;
            rpc_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NTHREADS; i++) begin
                state_q[i] <= state_d[i];
                kind_q[i]  <= kind_d[i];
                pc_q[i]    <= pc_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rr_q      <= rr_d;
            inv_en_q  <= inv_en_d;
            inv_thr_q <= inv_thr_d;
            rpc_q     <= rpc_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NTHREADS; i++) begin
            thread_stall_o[i] = (state_q[i] != StIdle);
        end
    end

    assign busy_o              = |thread_stall_o;
    assign invalidate_en_o     = inv_en_q;
    assign invalidate_thread_o = inv_thr_q;
    assign redirect_en_o       = inv_en_q;
    assign redirect_thread_o   = inv_thr_q;
    assign redirect_pc_o       = rpc_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: directed scenarios plus random traffic against a timestamp-based model.
module tb_flush_ctrl;
    localparam int N   = 4;
    localparam int D   = 5;
    localparam int PCW = 32;
    localparam int TW  = 2;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           br_req_i = 1'b0;
    logic [TW-1:0]  br_thread_i = '0;
    logic [PCW-1:0] br_target_i = '0;
    logic           exc_req_i = 1'b0;
    logic [TW-1:0]  exc_thread_i = '0;
    logic [PCW-1:0] exc_pc_i = '0;
    logic           invalidate_en_o;
    logic [TW-1:0]  invalidate_thread_o;
    logic           redirect_en_o;
    logic [TW-1:0]  redirect_thread_o;
    logic [PCW-1:0] redirect_pc_o;
    logic [N-1:0]   thread_stall_o;
    logic           busy_o;

    flush_ctrl #(.NTHREADS(N), .DRAIN(D), .PCW(PCW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .br_req_i           (br_req_i),
        .br_thread_i        (br_thread_i),
        .br_target_i        (br_target_i),
        .exc_req_i          (exc_req_i),
        .exc_thread_i       (exc_thread_i),
        .exc_pc_i           (exc_pc_i),
        .invalidate_en_o    (invalidate_en_o),
        .invalidate_thread_o(invalidate_thread_o),
        .redirect_en_o      (redirect_en_o),
        .redirect_thread_o  (redirect_thread_o),
        .redirect_pc_o      (redirect_pc_o),
        .thread_stall_o     (thread_stall_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a thread is pending (with kind/pc) or stalled until the last cycle of its drain
    bit             m_pend [N];
    bit             m_exc  [N];
    logic [PCW-1:0] m_pc   [N];
    int             m_dend [N];
    int             m_rr;
    bit             e_en;
    int             e_thr;
    logic [PCW-1:0] e_pc;
    int             cyc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_exc[i] = 0; m_pc[i] = '0; m_dend[i] = -1;
        end
        m_rr = 0; e_en = 0; e_thr = 0; e_pc = '0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] es;
        for (int i = 0; i < N; i++) es[i] = m_pend[i] || (cyc <= m_dend[i]);
        check_eq("inv_en", invalidate_en_o, e_en);
        check_eq("redir_en", redirect_en_o, e_en);
        if (e_en) begin
            check_eq("inv_thread", invalidate_thread_o, e_thr);
            check_eq("redir_thread", redirect_thread_o, e_thr);
            check_eq("redir_pc", redirect_pc_o, e_pc);
        end
        check_eq("stall", thread_stall_o, es);
        check_eq("busy", busy_o, |es);
    endtask

    task automatic model_update(input bit br, input int bt, input logic [PCW-1:0] bp,
                                input bit ex, input int et, input logic [PCW-1:0] ep);
        bit idle_old [N];
        bit found;
        bit coll;
        int g;
        found = 0; g = 0;
        for (int i = 0; i < N; i++) idle_old[i] = !m_pend[i] && (cyc > m_dend[i]);
        for (int k = 0; k < N; k++) begin
            if (!found && m_pend[(m_rr + k) % N]) begin
                found = 1; g = (m_rr + k) % N;
            end
        end
        coll = found && !m_exc[g] && ex && (et == g);
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && !m_exc[i] && ex && et == i) begin
                m_exc[i] = 1; m_pc[i] = ep;
            end else if (idle_old[i]) begin
                if (ex && et == i) begin
                    m_pend[i] = 1; m_exc[i] = 1; m_pc[i] = ep;
                end else if (br && bt == i) begin
                    m_pend[i] = 1; m_exc[i] = 0; m_pc[i] = bp;
                end
            end
        end
        if (found && !coll) begin
            e_en = 1; e_thr = g; e_pc = m_pc[g];
            m_pend[g] = 0; m_dend[g] = cyc + D; m_rr = (g + 1) % N;
        end else begin
            e_en = 0; e_thr = 0; e_pc = '0;
        end
    endtask

    task automatic step(input bit br, input int bt, input logic [PCW-1:0] bp,
                        input bit ex, input int et, input logic [PCW-1:0] ep);
        check_outputs();
        br_req_i = br; br_thread_i = bt[TW-1:0]; br_target_i = bp;
        exc_req_i = ex; exc_thread_i = et[TW-1:0]; exc_pc_i = ep;
        model_update(br, bt, bp, ex, et, ep);
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        model_reset();
        cyc = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Single branch on thread 2
        step(1, 2, 32'h100, 0, 0, '0);
        idle(1);
        check_eq("sb_en", invalidate_en_o, 1);
        check_eq("sb_thread", invalidate_thread_o, 2);
        check_eq("sb_pc", redirect_pc_o, 32'h100);
        idle(4);
        check_eq("sb_stall6", thread_stall_o[2], 1);
        idle(1);
        check_eq("sb_stall7", thread_stall_o[2], 0);
        idle(2);

        // Branch and exception on the same thread: exception wins
        step(1, 1, 32'h40, 1, 1, 32'h80);
        idle(1);
        check_eq("col_pc", redirect_pc_o, 32'h80);
        check_eq("col_thread", invalidate_thread_o, 1);
        idle(8);

        // Exception overwrites the entry in its grant cycle
        step(1, 0, 32'h10, 0, 0, '0);
        step(0, 0, '0, 1, 0, 32'h20);
        check_eq("ovr_nopulse", invalidate_en_o, 0);
        idle(1);
        check_eq("ovr_en", invalidate_en_o, 1);
        check_eq("ovr_pc", redirect_pc_o, 32'h20);
        idle(8);

        // Round-robin with rr=1: threads 1,3,0 pending together
        step(1, 1, 32'h111, 1, 3, 32'h333);
        step(1, 0, 32'h000, 0, 0, '0);
        check_eq("rr_a", invalidate_thread_o, 1);
        idle(1);
        check_eq("rr_b", invalidate_thread_o, 3);
        idle(1);
        check_eq("rr_c", invalidate_thread_o, 0);
        check_eq("rr_c_en", invalidate_en_o, 1);
        idle(8);

        // Branch arriving during drain is dropped
        step(1, 2, 32'h200, 0, 0, '0);
        idle(1);
        check_eq("drn_en", invalidate_en_o, 1);
        idle(1);
        step(1, 2, 32'h300, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            check_eq("drn_nopulse", invalidate_en_o, 0);
            idle(1);
        end
        check_eq("drn_stall", thread_stall_o[2], 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, N - 1), $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, N - 1), $urandom);
        end
        idle(D + 4);

        // Asynchronous reset with threads pending and draining
        step(1, 2, 32'h500, 1, 0, 32'h600);
        idle(1);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("rst_inv", invalidate_en_o, 0);
        check_eq("rst_redir", redirect_en_o, 0);
        check_eq("rst_pc", redirect_pc_o, 0);
        check_eq("rst_stall", thread_stall_o, 0);
        check_eq("rst_busy", busy_o, 0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc++;
        step(1, 2, 32'h100, 0, 0, '0);
        idle(1);
        check_eq("rst_sb_en", invalidate_en_o, 1);
        check_eq("rst_sb_pc", redirect_pc_o, 32'h100);
        idle(D + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
